// File: rtl/if_id_stage_buffer_if.sv
// Fetch-to-decode handshake bundle: fetch push side, decode pop side and the
// decoded head fields.
interface if_id_stage_buffer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pc;
  logic [DATA_W-1:0] in_instr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc4;
  logic [DATA_W-1:0] out_instr;
  logic [6:0]        out_opcode;
  logic [4:0]        out_rd;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [11:0]       out_imm;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_pc4, out_instr,
           out_opcode, out_rd, out_rs1, out_rs2, out_imm, stall_count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_pc4, out_instr,
           out_opcode, out_rd, out_rs1, out_rs2, out_imm, stall_count
  );
endinterface

// File: rtl/if_id_stage_buffer.sv
// IF/ID stage: 2-entry skid buffer of {pc, instr} with RISC-V field split,
// flush on redirect and a saturating decode-stall counter.
module if_id_stage_buffer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic                clk,
  input logic                rst,
  if_id_stage_buffer_if.slave bus
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] main_pc, skid_pc;
  logic [DATA_W-1:0] main_instr, skid_instr;
  logic [CNT_W-1:0]  stall_q;
  logic              push, pop;

  // in_ready comes only from state so decode never reaches back into fetch
  assign bus.in_ready  = (state != FULL);
  assign bus.out_valid = (state != EMPTY);
  assign push = bus.in_valid & bus.in_ready & ~bus.flush & ~rst;
  assign pop  = bus.out_valid & bus.out_ready;

  // invalid entries hold zero payload, so the head fields read 0 when empty
  assign bus.out_pc      = main_pc;
  assign bus.out_pc4     = main_pc + ADDR_W'(4);
  assign bus.out_instr   = main_instr;
  assign bus.out_opcode  = main_instr[6:0];
  assign bus.out_rd      = main_instr[11:7];
  assign bus.out_rs1     = main_instr[19:15];
  assign bus.out_rs2     = main_instr[24:20];
  assign bus.out_imm     = main_instr[31:20];
  assign bus.stall_count = stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      main_pc    <= '0;
      main_instr <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
      stall_q    <= '0;
    end else begin
      if (bus.out_valid && !bus.out_ready && stall_q != '1)
        stall_q <= stall_q + CNT_W'(1);

      if (bus.flush) begin
        state      <= EMPTY;
        main_pc    <= '0;
        main_instr <= '0;
        skid_pc    <= '0;
        skid_instr <= '0;
      end else begin
        case (state)
          EMPTY: begin
            if (push) begin
              main_pc    <= bus.in_pc;
              main_instr <= bus.in_instr;
              state      <= ONE;
            end
          end
          ONE: begin
            if (push && pop) begin
              main_pc    <= bus.in_pc;
              main_instr <= bus.in_instr;
            end else if (push) begin
              skid_pc    <= bus.in_pc;
              skid_instr <= bus.in_instr;
              state      <= FULL;
            end else if (pop) begin
              main_pc    <= '0;
              main_instr <= '0;
              state      <= EMPTY;
            end
          end
          FULL: begin
            if (pop) begin
              main_pc    <= skid_pc;
              main_instr <= skid_instr;
              skid_pc    <= '0;
              skid_instr <= '0;
              state      <= ONE;
            end
          end
          default: begin
            state      <= EMPTY;
            main_pc    <= '0;
            main_instr <= '0;
            skid_pc    <= '0;
            skid_instr <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_if_id_stage_buffer.sv
// Directed vector bench for if_id_stage_buffer: table of per-cycle stimulus
// with expected post-edge outputs, plus streaming and counter-saturation runs.
module tb_if_id_stage_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  if_id_stage_buffer_if #(.ADDR_W(8), .DATA_W(32), .CNT_W(16)) bus ();
  if_id_stage_buffer_if #(.ADDR_W(8), .DATA_W(32), .CNT_W(4))  bus2 ();

  if_id_stage_buffer #(.ADDR_W(8), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  if_id_stage_buffer #(.ADDR_W(8), .DATA_W(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [7:0]  pc;
    logic [31:0] instr;
    logic        ordy;
    logic        ov;
    logic        ir;
    logic [7:0]  opc;
    logic [7:0]  opc4;
    logic [31:0] oinstr;
    logic [15:0] st;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic f, input logic iv, input logic [7:0] pc,
                     input logic [31:0] instr, input logic ordy, input logic ov,
                     input logic ir, input logic [7:0] opc, input logic [7:0] opc4,
                     input logic [31:0] oinstr, input logic [15:0] st);
    vec_t v;
    v = '{r, f, iv, pc, instr, ordy, ov, ir, opc, opc4, oinstr, st};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    bus.in_valid = 0; bus.in_pc = '0; bus.in_instr = '0; bus.flush = 0; bus.out_ready = 0;
    bus2.in_valid = 0; bus2.in_pc = '0; bus2.in_instr = '0; bus2.flush = 0; bus2.out_ready = 0;

    //   rst f iv pc     instr         rdy ov ir out_pc pc4    out_instr     stall
    add(1, 0, 1, 8'h04, 32'h00450693, 0,  0, 1, 8'h00, 8'h04, 32'h0,        16'd0); // push during rst dropped
    add(0, 0, 1, 8'h04, 32'h00450693, 0,  1, 1, 8'h04, 8'h08, 32'h00450693, 16'd0);
    add(0, 0, 0, 8'h00, 32'h0,        0,  1, 1, 8'h04, 8'h08, 32'h00450693, 16'd1);
    add(0, 0, 0, 8'h00, 32'h0,        0,  1, 1, 8'h04, 8'h08, 32'h00450693, 16'd2);
    add(0, 0, 0, 8'h00, 32'h0,        1,  0, 1, 8'h00, 8'h04, 32'h0,        16'd2);
    add(0, 0, 1, 8'h20, 32'hffc62883, 0,  1, 1, 8'h20, 8'h24, 32'hffc62883, 16'd2); // idx 5
    add(0, 0, 1, 8'h24, 32'h01185a63, 0,  1, 0, 8'h20, 8'h24, 32'hffc62883, 16'd3);
    add(0, 0, 1, 8'h28, 32'h00000013, 0,  1, 0, 8'h20, 8'h24, 32'hffc62883, 16'd4);
    add(0, 0, 1, 8'h28, 32'h00000013, 1,  1, 1, 8'h24, 8'h28, 32'h01185a63, 16'd4);
    add(0, 0, 0, 8'h00, 32'h0,        1,  0, 1, 8'h00, 8'h04, 32'h0,        16'd4);
    add(0, 0, 1, 8'h30, 32'h00100093, 0,  1, 1, 8'h30, 8'h34, 32'h00100093, 16'd4);
    add(0, 0, 1, 8'h34, 32'h00200113, 0,  1, 0, 8'h30, 8'h34, 32'h00100093, 16'd5);
    add(0, 1, 1, 8'h38, 32'h00300193, 1,  0, 1, 8'h00, 8'h04, 32'h0,        16'd5); // flush in FULL
    add(0, 0, 0, 8'h00, 32'h0,        0,  0, 1, 8'h00, 8'h04, 32'h0,        16'd5);
    add(0, 0, 1, 8'h40, 32'h00400213, 0,  1, 1, 8'h40, 8'h44, 32'h00400213, 16'd5);
    add(0, 1, 1, 8'h44, 32'h00500293, 0,  0, 1, 8'h00, 8'h04, 32'h0,        16'd6); // stall edge still counted
    add(0, 0, 1, 8'hFC, 32'h00000013, 0,  1, 1, 8'hFC, 8'h00, 32'h00000013, 16'd6); // pc4 wraps
    add(0, 0, 1, 8'h00, 32'h00600313, 1,  1, 1, 8'h00, 8'h04, 32'h00600313, 16'd6);
    add(0, 0, 0, 8'h00, 32'h0,        1,  0, 1, 8'h00, 8'h04, 32'h0,        16'd6);
    add(0, 0, 1, 8'h50, 32'h00700393, 0,  1, 1, 8'h50, 8'h54, 32'h00700393, 16'd6);
    add(0, 0, 1, 8'h54, 32'h00800413, 0,  1, 0, 8'h50, 8'h54, 32'h00700393, 16'd7);
    add(1, 1, 1, 8'h58, 32'h00900493, 1,  0, 1, 8'h00, 8'h04, 32'h0,        16'd0); // rst beats all
    add(0, 0, 0, 8'h00, 32'h0,        0,  0, 1, 8'h00, 8'h04, 32'h0,        16'd0);

    foreach (vq[i]) begin
      rst = vq[i].rst; bus.flush = vq[i].flush; bus.in_valid = vq[i].iv;
      bus.in_pc = vq[i].pc; bus.in_instr = vq[i].instr; bus.out_ready = vq[i].ordy;
      @(posedge clk); #1;
      chk("out_valid", i, 32'(bus.out_valid), 32'(vq[i].ov));
      chk("in_ready", i, 32'(bus.in_ready), 32'(vq[i].ir));
      chk("out_pc", i, 32'(bus.out_pc), 32'(vq[i].opc));
      chk("out_pc4", i, 32'(bus.out_pc4), 32'(vq[i].opc4));
      chk("out_instr", i, bus.out_instr, vq[i].oinstr);
      chk("stall_count", i, 32'(bus.stall_count), 32'(vq[i].st));
      if (i == 1) begin
        chk("opcode", i, 32'(bus.out_opcode), 32'h13);
        chk("rd", i, 32'(bus.out_rd), 32'd13);
        chk("rs1", i, 32'(bus.out_rs1), 32'd10);
        chk("rs2", i, 32'(bus.out_rs2), 32'd4);
        chk("imm", i, 32'(bus.out_imm), 32'h004);
      end
      if (i == 5) begin
        chk("rd", i, 32'(bus.out_rd), 32'd17);
        chk("rs1", i, 32'(bus.out_rs1), 32'd12);
        chk("imm", i, 32'(bus.out_imm), 32'hFFC);
        chk("opcode", i, 32'(bus.out_opcode), 32'h03);
      end
    end

    // streaming: one instruction per cycle, never backpressured
    rst = 0; bus.flush = 0; bus.out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1; bus.in_pc = 8'(i * 4); bus.in_instr = 32'h13 | (32'(i) << 7);
      @(posedge clk); #1;
      chk("stream_valid", i, 32'(bus.out_valid), 32'd1);
      chk("stream_pc", i, 32'(bus.out_pc), 32'(i * 4));
      chk("stream_rd", i, 32'(bus.out_rd), 32'(i));
      chk("stream_ready", i, 32'(bus.in_ready), 32'd1);
      chk("stream_stall", i, 32'(bus.stall_count), 32'd0);
    end
    bus.in_valid = 0;
    @(posedge clk); #1;
    chk("stream_drain", 0, 32'(bus.out_valid), 32'd0);

    // 4-bit counter saturation
    @(posedge clk); #1;
    rst2 = 0; bus2.in_valid = 1; bus2.in_pc = 8'h10; bus2.in_instr = 32'h00000013;
    @(posedge clk); #1;
    bus2.in_valid = 0;
    chk("sat_valid", 0, 32'(bus2.out_valid), 32'd1);
    chk("sat_start", 0, 32'(bus2.stall_count), 32'd0);
    repeat (14) @(posedge clk);
    #1 chk("sat_14", 0, 32'(bus2.stall_count), 32'd14);
    repeat (6) @(posedge clk);
    #1 chk("sat_hold", 0, 32'(bus2.stall_count), 32'hF);
    rst2 = 1;
    @(posedge clk); #1;
    chk("sat_rst", 0, 32'(bus2.stall_count), 32'd0);
    chk("sat_rst_valid", 0, 32'(bus2.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/if_id_stage_buffer.md
Name: if_id_stage_buffer

Overview:
- Fetch-to-decode pipeline stage, directly downstream of the PC/ROM fetch path.
- Accepts fetched {pc, instr} pairs over a valid/ready handshake and holds them in a 2-entry skid buffer, so fetch never sees a combinational ready path from decode.
- Presents the head entry with its RISC-V fields already split out: opcode, rd, rs1, rs2, imm, pc+4.
- Supports flush for branch/jump redirect and keeps a saturating stall counter for performance debug.

Parameters:
ADDR_W, 8, PC width in bits
DATA_W, 32, instruction width in bits (fixed at 32; field slicing assumes it)
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  fetch presents a valid {in_pc, in_instr}
in_ready  output  1  buffer can accept; equals NOT skid_full (registered state, no combinational path from out_ready)
in_pc  input  ADDR_W  PC of fetched instruction
in_instr  input  DATA_W  fetched instruction word
flush  input  1  discard all buffered entries and any same-cycle push
out_valid  output  1  head entry valid
out_ready  input  1  decode consumes head this cycle
out_pc  output  ADDR_W  head PC
out_pc4  output  ADDR_W  head PC + 4, modulo 2^ADDR_W
out_instr  output  DATA_W  head instruction
out_opcode  output  7  out_instr[6:0]
out_rd  output  5  out_instr[11:7]
out_rs1  output  5  out_instr[19:15]
out_rs2  output  5  out_instr[24:20]
out_imm  output  12  out_instr[31:20], raw, not sign-extended
stall_count  output  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Storage: main entry (head, drives out_*) and skid entry, each holding {valid, pc, instr}.
- State encoding: EMPTY (neither valid), ONE (main only), FULL (main and skid).
- Definitions: push = in_valid & in_ready & ~flush & ~rst; pop = out_valid & out_ready.
- EMPTY:
  - push: load main, go to ONE.
  - otherwise stay EMPTY.
- ONE:
  - push & pop: load main with new data, stay ONE.
  - push only: load skid, go to FULL.
  - pop only: go to EMPTY.
  - neither: hold.
- FULL (in_ready=0, so push impossible):
  - pop: skid moves to main, skid cleared, go to ONE.
  - otherwise hold.
- Order: strict FIFO. Latency is 1 cycle: data pushed at edge N is visible on out_* after edge N if the buffer was EMPTY, or after the pop that exposes it.
- Zeroing: the pc/instr payload of any invalid entry is 0. When out_valid=0, all out_* fields read 0, except out_pc4, which reads 8'h04.
- Flush: at the next edge both entries are invalidated and zeroed, the state goes to EMPTY, and any same-cycle push is dropped. Flush is legal in any state, and flush with pop is the same as flush alone. in_ready is 1 the cycle after a flush.
- Reset: takes priority over flush and all handshakes. Reset values:
  - out_valid=0, skid_full=0, in_ready=1.
  - all payloads 0; stall_count=0.
  - A push presented during rst is dropped.
- stall_count:
  - Increments by 1 on each edge where out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by rst; flush does not clear it.
- Arithmetic: out_pc4 = out_pc + 4, truncated to ADDR_W, so 8'hFC gives 8'h00. Field outputs are pure slices of the main entry's registered instr.

Test Plan:
- Reset then single push: in_pc=8'h04, in_instr=32'h00450693, out_ready=0. Next cycle:
  - out_valid=1, out_opcode=7'h13, out_rd=13, out_rs1=10, out_rs2=4, out_imm=12'h004, out_pc4=8'h08.
  - stall_count increments every subsequent cycle.
- Fill/backpressure: push 8'h20/32'hffc62883 then 8'h24/32'h01185a63 with out_ready=0.
  - After edge 2, in_ready=0 (FULL); a third push is not accepted.
  - Head shows rd=17, rs1=12, imm=12'hFFC.
  - Raising out_ready pops 8'h20, then 8'h24, in order; in_ready returns to 1 after the first pop.
- Streaming: in_valid=1 and out_ready=1 continuously with PCs 0x00..0x4C.
  - out_valid stays 1 from the second cycle onward, one instruction per cycle, PCs strictly increasing by 4.
  - in_ready is never 0; stall_count stays 0.
- Flush in FULL with in_valid=1 on the same cycle:
  - Next cycle out_valid=0, out_instr=0, out_pc4=8'h04, in_ready=1.
  - The same-cycle input is absent; stall_count is unchanged by the flush.
- Wrap and saturation:
  - Push in_pc=8'hFC: requires out_pc4=8'h00.
  - With CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles: stall_count stops at 4'hF; rst returns it to 0.
- Reset mid-operation: assert rst while FULL with pop and flush also active.
  - Next cycle every output is at its reset value.
  - A push on the rst cycle is not captured.
